// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with write-to-read bypass,
// per-entry busy scoreboard and a one-entry-per-cycle clear sequencer.
//
// Ports
//   clk_i         single clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset, overrides everything
//   wr_en_i       per-port write enable (higher port index wins on collision)
//   wr_addr_i     packed write addresses, port k at [k*AW +: AW]
//   wr_data_i     packed write data, port k at [k*DATA_W +: DATA_W]
//   rd_addr_i     packed read addresses
//   rd_data_o     packed combinational read data
//   rd_busy_o     addressed entry has an outstanding producer
//   issue_en_i    reserve issue_addr_i as the destination of an issued op
//   issue_addr_i  destination being reserved
//   clear_req_i   start a clear sweep (honoured only when idle)
//   clear_busy_o  sweep in progress
//
// Clear FSM
//   state   | meaning
//   S_IDLE  | normal operation, writes/issues accepted, clear_req_i sampled
//   S_CLEAR | zero entry cnt_q and its busy bit each cycle; writes/issues dropped

module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     issue_en_i,
    input  logic [AW-1:0]            issue_addr_i,
    input  logic                     clear_req_i,
    output logic                     clear_busy_o
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    logic                idle;
    logic [NUM_WR-1:0]   wr_ok;
    logic [NUM_REGS-1:0] ent_we;
    logic [DATA_W-1:0]   ent_wd [NUM_REGS];
    logic                issue_ok;
    logic [AW-1:0]       rd_addr [NUM_RD];

    // An address names a real, writable entry: in range and not the hardwired zero.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(NUM_REGS)) && !(ZERO_REG && (a == '0));
    endfunction

    assign idle         = (state_q == S_IDLE);
    assign clear_busy_o = (state_q == S_CLEAR);
    assign issue_ok     = idle && issue_en_i && addr_ok(issue_addr_i);

    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_ok[k] = idle && wr_en_i[k] && addr_ok(wr_addr_i[k*AW +: AW]);
        end
    end

    // Per-entry write resolution: ascending port order so the highest index wins.
    always_comb begin
        ent_we = '0;
        for (int a = 0; a < NUM_REGS; a++) begin
            ent_wd[a] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_ok[k] && (wr_addr_i[k*AW +: AW] == AW'(a))) begin
                    ent_we[a] = 1'b1;
                    ent_wd[a] = wr_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NUM_REGS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= '0;
            for (int a = 0; a < NUM_REGS; a++) begin
                mem_q[a] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int a = 0; a < NUM_REGS; a++) begin
                if (!idle) begin
                    if (cnt_q == AW'(a)) begin
                        mem_q[a]  <= '0;
                        busy_q[a] <= 1'b0;
                    end
                end else begin
                    if (ent_we[a]) begin
                        mem_q[a] <= ent_wd[a];
                    end
                    // A new reservation outranks the writeback that retires the old one.
                    if (issue_ok && (issue_addr_i == AW'(a))) begin
                        busy_q[a] <= 1'b1;
                    end else if (ent_we[a]) begin
                        busy_q[a] <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr[i] = rd_addr_i[i*AW +: AW];
        end
    end

    // ent_we is all-zero during a sweep, so no bypass happens while clearing.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (addr_ok(rd_addr[i])) begin
                if (BYPASS && ent_we[rd_addr[i]]) begin
                    rd_data_o[i*DATA_W +: DATA_W] = ent_wd[rd_addr[i]];
                    rd_busy_o[i]                  = 1'b0;
                end else begin
                    rd_data_o[i*DATA_W +: DATA_W] = mem_q[rd_addr[i]];
                    rd_busy_o[i]                  = busy_q[rd_addr[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

    logic         clk;
    logic         rst;

    // main instance: default parameters
    logic         we [2];
    logic [4:0]   wa [2];
    logic [31:0]  wd [2];
    logic [4:0]   ra [4];
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data;
    logic [3:0]   rd_busy;
    logic         issue_en;
    logic [4:0]   issue_addr;
    logic         clear_req;
    logic         clear_busy;

    // second instance: 24 entries, no bypass, no zero register
    logic [1:0]   b_wr_en;
    logic [9:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic [9:0]   b_rd_addr;
    logic [63:0]  b_rd_data;
    logic [1:0]   b_rd_busy;
    logic         b_issue_en;
    logic [4:0]   b_issue_addr;
    logic         b_clear_req;
    logic         b_clear_busy;

    int n_checks = 0;
    int n_errors = 0;

    // reference state
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    int          m_pos;      // sweep position, -1 when not sweeping
    logic        obs_cb;

    assign wr_en   = {we[1], we[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};
    assign rd_addr = {ra[3], ra[2], ra[1], ra[0]};

    reg_file_mp dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .clear_req_i(clear_req), .clear_busy_o(clear_busy)
    );

    reg_file_mp #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(2), .NUM_WR(2),
                  .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
        .issue_en_i(b_issue_en), .issue_addr_i(b_issue_addr),
        .clear_req_i(b_clear_req), .clear_busy_o(b_clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        for (int k = 0; k < 2; k++) begin
            we[k] = 1'b0;
            wa[k] = '0;
            wd[k] = '0;
        end
        issue_en   = 1'b0;
        issue_addr = '0;
        clear_req  = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end
        m_pos = -1;
    endtask

    // Check all outputs of the main instance against the model, then clock once.
    task automatic step();
        #1;
        for (int i = 0; i < 4; i++) begin
            logic [4:0]  a;
            logic [31:0] exp_d;
            logic        exp_b;
            int          w;
            a = ra[i];
            w = -1;
            for (int k = 0; k < 2; k++) begin
                if (m_pos < 0 && we[k] && wa[k] == a && a != 0) w = k;
            end
            if (a == 0) begin
                exp_d = '0;
                exp_b = 1'b0;
            end else if (w >= 0) begin
                exp_d = wd[w];
                exp_b = 1'b0;
            end else begin
                exp_d = m_mem[a];
                exp_b = m_busy[a];
            end
            chk($sformatf("rd_data%0d@%0d", i, a), rd_data[i*32 +: 32], exp_d);
            chk($sformatf("rd_busy%0d@%0d", i, a), 32'(rd_busy[i]), 32'(exp_b));
        end
        chk("clear_busy", 32'(clear_busy), 32'(m_pos >= 0));
        obs_cb = clear_busy;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_pos >= 0) begin
            m_mem[m_pos]  = '0;
            m_busy[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == 32) m_pos = -1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we[k] && wa[k] != 0) begin
                    m_mem[wa[k]]  = wd[k];
                    m_busy[wa[k]] = 1'b0;
                end
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            if (clear_req) m_pos = 0;
        end
        #1;
    endtask

    initial begin
        int cb_cnt;
        idle_in();
        for (int i = 0; i < 4; i++) ra[i] = '0;
        b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        b_issue_en = 1'b0; b_issue_addr = '0; b_clear_req = 1'b0;

        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;

        // reset state across all addresses
        for (int a = 0; a < 32; a += 4) begin
            for (int i = 0; i < 4; i++) ra[i] = 5'(a + i);
            step();
        end

        // second instance: no bypass, entry 0 writable, out-of-range dropped
        b_wr_en = 2'b11; b_wr_addr = {5'd5, 5'd5};
        b_wr_data = {32'h5555_1111, 32'hAAAA_0000}; b_rd_addr = {5'd0, 5'd5};
        #1 chk("b_same_cycle_old", b_rd_data[31:0], 32'h0);
        step();
        b_wr_addr = {5'd30, 5'd0}; b_wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
        #1 chk("b_next_cycle", b_rd_data[31:0], 32'h5555_1111);
        step();
        b_wr_en = 2'b00; b_rd_addr = {5'd30, 5'd0};
        b_issue_en = 1'b1; b_issue_addr = 5'd7;
        #1 chk("b_addr0", b_rd_data[31:0], 32'hDEAD_BEEF);
        chk("b_addr30", b_rd_data[63:32], 32'h0);
        step();
        b_issue_en = 1'b0; b_rd_addr = {5'd0, 5'd7};
        b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd7}; b_wr_data = {32'h0, 32'h77};
        #1 chk("b_busy_issue", 32'(b_rd_busy[0]), 32'd1);
        chk("b_busy_no_bypass", b_rd_data[31:0], 32'h0);
        step();
        b_wr_en = 2'b00;
        #1 chk("b_busy_retired", 32'(b_rd_busy[0]), 32'd0);
        chk("b_write7", b_rd_data[31:0], 32'h77);
        step();

        // zero register
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hDEAD_BEEF; ra[0] = 5'd0;
        step();
        idle_in();
        #1 chk("zero_reg", rd_data[31:0], 32'h0);
        step();

        // same-address write collision with bypass
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hAAAA_0000;
        we[1] = 1'b1; wa[1] = 5'd5; wd[1] = 32'h5555_1111; ra[0] = 5'd5;
        #1 chk("bypass_win", rd_data[31:0], 32'h5555_1111);
        step();
        idle_in();
        #1 chk("collision_stored", rd_data[31:0], 32'h5555_1111);
        step();

        // scoreboard
        ra[0] = 5'd7; issue_en = 1'b1; issue_addr = 5'd7;
        step();
        idle_in();
        #1 chk("busy_after_issue", 32'(rd_busy[0]), 32'd1);
        step();
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h7;
        #1 chk("busy_bypass_clear", 32'(rd_busy[0]), 32'd0);
        step();
        idle_in();
        #1 chk("busy_stays_clear", 32'(rd_busy[0]), 32'd0);
        step();
        issue_en = 1'b1; issue_addr = 5'd7; we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h70;
        step();
        idle_in();
        #1 chk("issue_beats_write", 32'(rd_busy[0]), 32'd1);
        step();

        // fill 1..31 with own index, then sweep
        for (int e = 1; e < 32; e += 2) begin
            we[0] = 1'b1; wa[0] = 5'(e);     wd[0] = 32'(e);
            we[1] = 1'b1; wa[1] = 5'(e + 1); wd[1] = 32'(e + 1);
            step();
        end
        idle_in();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        cb_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            idle_in();
            ra[0] = 5'd31; ra[1] = 5'(c % 32);
            if (c == 5) begin
                we[0] = 1'b1; wa[0] = 5'd31; wd[0] = 32'hFFFF_FFFF;
                clear_req = 1'b1;
                #1 chk("mid_sweep_31", rd_data[31:0], 32'd31);
            end
            step();
            if (obs_cb) cb_cnt++;
            else break;
        end
        idle_in();
        chk("sweep_len", 32'(cb_cnt), 32'd32);
        for (int a = 0; a < 32; a += 4) begin
            for (int i = 0; i < 4; i++) ra[i] = 5'(a + i);
            #1 chk("post_sweep", rd_data[31:0], 32'h0);
            step();
        end

        // reset in the middle of a sweep
        for (int e = 20; e < 28; e += 2) begin
            we[0] = 1'b1; wa[0] = 5'(e);     wd[0] = 32'h100 + 32'(e);
            we[1] = 1'b1; wa[1] = 5'(e + 1); wd[1] = 32'h100 + 32'(e + 1);
            step();
        end
        idle_in();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("rst_mid_sweep", 32'(clear_busy), 32'd0);
        for (int a = 20; a < 28; a += 4) begin
            for (int i = 0; i < 4; i++) ra[i] = 5'(a + i);
            #1 chk("rst_cleared", rd_data[31:0], 32'h0);
            step();
        end
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        #1 chk("restart_sweep", 32'(clear_busy), 32'd1);
        step();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                we[k] = 1'($urandom_range(0, 1));
                wa[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                     : 5'($urandom_range(0, 7));
                wd[k] = $urandom;
            end
            for (int i = 0; i < 4; i++) begin
                ra[i] = ($urandom_range(0, 1) == 0) ? wa[$urandom_range(0, 1)]
                                                     : 5'($urandom_range(0, 31));
            end
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            clear_req  = ($urandom_range(0, 59) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            step();
        end
        idle_in();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the next-generation RV32IM core, serving a dual-issue decode stage and a multi-writeback pipeline. It generalises the 32x32 file to configurable width, depth, read-port count and write-port count. It adds an optional write-to-read bypass, a per-register busy scoreboard for hazard detection, and a one-entry-per-cycle clear sequencer.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of entries (2..64); AW = $clog2(NUM_REGS)
- NUM_RD, 4, read ports (1..8)
- NUM_WR, 2, write ports (1..4); a higher index has higher priority
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read returns old data
- ZERO_REG, 1, 1 = entry 0 hardwired to zero and never busy
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- wr_en_i  in  NUM_WR  per-port write enable
- wr_addr_i  in  NUM_WR*AW  packed write addresses, port k at [k*AW +: AW]
- wr_data_i  in  NUM_WR*DATA_W  packed write data
- rd_addr_i  in  NUM_RD*AW  packed read addresses
- rd_data_o  out  NUM_RD*DATA_W  packed combinational read data
- rd_busy_o  out  NUM_RD  addressed entry has an outstanding producer
- issue_en_i  in  1  mark issue_addr_i busy (instruction issued with destination)
- issue_addr_i  in  AW  destination being reserved
- clear_req_i  in  1  start a clear sweep (sampled only in IDLE)
- clear_busy_o  out  1  sweep in progress

## Operation
- Storage: NUM_REGS x DATA_W flops. Scoreboard: NUM_REGS busy bits.
- Write: entry a updates with the data of the highest-index port k that has wr_en_i[k] and wr_addr_i[k]==a. Lower-index writes to the same address are dropped.
- Ignored writes: writes to address 0 when ZERO_REG=1, and writes to addresses >= NUM_REGS.
- Read: rd_data_o[i] is 0 when the address is 0 (ZERO_REG=1) or >= NUM_REGS. Otherwise it is the array contents.
- With BYPASS=1, if an accepted write targets the read address in the same cycle, rd_data_o[i] returns the winning write data.
- Scoreboard update per cycle, in order of increasing precedence:
  - An accepted write to a clears its busy bit.
  - issue_en_i sets the busy bit of issue_addr_i, ignored for address 0 (ZERO_REG=1) or out-of-range addresses. Issue overrides a same-cycle clear of the same entry.
- rd_busy_o[i] = busy[rd_addr_i[i]]. With BYPASS=1 it is forced to 0 when a same-cycle accepted write targets that address.
- Clear FSM, states IDLE and CLEAR, with counter cnt (AW bits):
  - IDLE -> CLEAR when clear_req_i=1; cnt <= 0.
  - CLEAR: entry cnt and busy[cnt] are zeroed each cycle and cnt increments. After clearing entry NUM_REGS-1, the FSM returns to IDLE.
  - Port writes and issue_en_i are ignored throughout CLEAR.
  - clear_req_i is ignored while in CLEAR.
  - Reads remain active and return partially cleared contents, with no bypass.

## Timing
- Reset (rst_i=1 at a rising edge): all entries = 0, all busy bits = 0, FSM in IDLE, cnt = 0. rst_i overrides every other input, including mid-sweep.
- Output values after reset: rd_data_o=0 for every address, rd_busy_o=0, clear_busy_o=0.
- Write latency: 1 cycle to the array (visible without bypass on the next cycle); 0 cycles via the bypass.
- Issue latency: busy is visible on rd_busy_o the cycle after issue_en_i.
- clear_busy_o is registered. It is high from the cycle after clear_req_i is accepted for exactly NUM_REGS cycles.
- A new clear_req_i is accepted the cycle clear_busy_o returns low. The sweep takes NUM_REGS+1 cycles from request to IDLE.
- Reads are purely combinational from registered state plus the current-cycle write inputs. There is no read latency.

## Test plan
- Reset then read all ports -> every rd_data_o=0, rd_busy_o=0, clear_busy_o=0.
- Write port0 addr 5 = 0xAAAA_0000 and port1 addr 5 = 0x5555_1111 in the same cycle, reading addr 5:
  - BYPASS=1 -> the same cycle reads 0x5555_1111.
  - Next cycle reads 0x5555_1111 in both modes.
  - BYPASS=0 -> the same cycle reads the old value 0.
- Write 0xDEADBEEF to addr 0 -> the read of addr 0 stays 0. With ZERO_REG=0 and NUM_REGS=24, writes to addr 0 and addr 30:
  - addr 0 reads 0xDEADBEEF.
  - addr 30 reads 0.
- Scoreboard, with a read port on addr 7:
  - issue addr 7 -> rd_busy_o=1 next cycle.
  - Write addr 7 -> rd_busy_o=0 in the same cycle (BYPASS=1) and stays 0.
  - Issue and write addr 7 in the same cycle -> busy remains 1.
- Fill entries 1..31 with their own index, then pulse clear_req_i:
  - clear_busy_o is high for 32 cycles.
  - Mid-sweep, entry 31 still reads 31 and a write to entry 31 is dropped.
  - After the sweep, all entries read 0.
- Assert rst_i during cycle 10 of a sweep -> next cycle clear_busy_o=0 and all entries read 0. A new clear_req_i is accepted immediately.
